// File: rtl/leg_solver_if.sv
// Request/response bundle for the leg solver: operands and start in,
// status and result out.
interface leg_solver_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [W-1:0] h_in;
  logic [W-1:0] x_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] y_out;

  modport master (
    output start, h_in, x_in,
    input  busy, done, err, y_out
  );

  modport slave (
    input  start, h_in, x_in,
    output busy, done, err, y_out
  );
endinterface

// File: rtl/leg_solver.sv
// Computes the missing leg y = floor(sqrt(h^2 - x^2)) with a bit-serial,
// MSB-first integer square root; flags err when x > h.
module leg_solver #(
  parameter int unsigned W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  leg_solver_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    DIFF = 3'd2,
    ROOT = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam logic [W-1:0] MASK_MSB = {1'b1, {(W-1){1'b0}}};

  state_e         state_q, state_d;
  logic [W-1:0]   h_q, h_d;
  logic [W-1:0]   x_q, x_d;
  logic [2*W-1:0] hsq_q, hsq_d;
  logic [2*W-1:0] xsq_q, xsq_d;
  logic [2*W-1:0] diff_q, diff_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   mask_q, mask_d;
  logic [W-1:0]   y_q, y_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [W-1:0]   trial;
  logic [2*W-1:0] trial_sq;
  logic [2*W-1:0] h_sq;
  logic [2*W-1:0] x_sq;

  // Squares are formed at full 2W width so h = 2^W-1 cannot overflow.
  assign trial    = res_q | mask_q;
  assign trial_sq = {{W{1'b0}}, trial} * {{W{1'b0}}, trial};
  assign h_sq     = {{W{1'b0}}, h_q} * {{W{1'b0}}, h_q};
  assign x_sq     = {{W{1'b0}}, x_q} * {{W{1'b0}}, x_q};

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    h_d     = h_q;
    x_d     = x_q;
    hsq_d   = hsq_q;
    xsq_d   = xsq_q;
    diff_d  = diff_q;
    res_d   = res_q;
    mask_d  = mask_q;
    y_d     = y_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.start) begin
          h_d     = bus.h_in;
          x_d     = bus.x_in;
          err_d   = 1'b0;
          state_d = SQ;
        end
      end
      SQ: begin
        hsq_d   = h_sq;
        xsq_d   = x_sq;
        state_d = DIFF;
      end
      DIFF: begin
        if (x_q > h_q) begin
          y_d     = '0;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          diff_d  = hsq_q - xsq_q;
          res_d   = '0;
          mask_d  = MASK_MSB;
          state_d = ROOT;
        end
      end
      ROOT: begin
        if (trial_sq <= diff_q) res_d = trial;
        mask_d = mask_q >> 1;
        // The LSB trial is the last one; no idle pass with an empty mask.
        if (mask_q[0]) state_d = FIN;
      end
      FIN: begin
        y_d     = res_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath registers are few and narrow, so all of them are
  // reset; this keeps stale operands from an aborted request out of view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      x_q     <= '0;
      hsq_q   <= '0;
      xsq_q   <= '0;
      diff_q  <= '0;
      res_q   <= '0;
      mask_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      h_q     <= h_d;
      x_q     <= x_d;
      hsq_q   <= hsq_d;
      xsq_q   <= xsq_d;
      diff_q  <= diff_d;
      res_q   <= res_d;
      mask_q  <= mask_d;
      y_q     <= y_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.y_out = y_q;

endmodule

// File: tb/tb_leg_solver.sv
// Scoreboard bench for leg_solver (W=8): directed requests push expected
// results; a monitor pops and compares on each rising done.
module tb_leg_solver;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] y;
    logic         err;
    int           t0;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;

  leg_solver_if #(.W(W)) bus ();

  leg_solver #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge of done.
  always @(negedge clk) begin
    if (rst_n && bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending request (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("y_out", int'(bus.y_out), int'(mon_e.y));
        check("err", int'(bus.err), int'(mon_e.err));
        check("latency", cyc - mon_e.t0, mon_e.lat);
      end
    end
    done_prev = bus.done;
  end

  // Wait for idle, present one request and (optionally) record the expectation.
  task automatic issue(input logic [W-1:0] h, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic e,
                       input int lat, input bit push);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("idle_timeout", k, 0);
    bus.start = 1'b1;
    bus.h_in  = h;
    bus.x_in  = x;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{y: y, err: e, t0: cyc, lat: lat});
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.start = 1'b0;
    bus.h_in  = '0;
    bus.x_in  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_y", int'(bus.y_out), 0);
    rst_n = 1'b1;

    // 5,3 -> 4: busy 11 cycles, single-cycle done
    issue(8'd5, 8'd3, 8'd4, 1'b0, 11, 1'b1);
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 50) begin
      k++;
      @(negedge clk);
    end
    check("busy_cycles", k + 0, 11);
    check("done_high", int'(bus.done), 1);
    @(negedge clk);
    check("done_pulse_width", int'(bus.done), 0);
    check("y_hold", int'(bus.y_out), 4);

    // Main function and boundary cases
    issue(8'd10,  8'd7,   8'd7,   1'b0, 11, 1'b1);
    issue(8'd255, 8'd0,   8'd255, 1'b0, 11, 1'b1);
    issue(8'd200, 8'd200, 8'd0,   1'b0, 11, 1'b1);
    issue(8'd0,   8'd0,   8'd0,   1'b0, 11, 1'b1);
    issue(8'd3,   8'd4,   8'd0,   1'b1, 2,  1'b1);
    issue(8'd13,  8'd5,   8'd12,  1'b0, 11, 1'b1);
    issue(8'd255, 8'd254, 8'd22,  1'b0, 11, 1'b1);

    // Reset during ROOT: outputs clear at once, no done follows
    issue(8'd10, 8'd7, 8'd7, 1'b0, 11, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_err", int'(bus.err), 0);
    check("abort_y", int'(bus.y_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_done", int'(bus.done), 0);
    issue(8'd13, 8'd5, 8'd12, 1'b0, 11, 1'b1);

    // ena low for 5 edges mid-ROOT, plus an ignored start while busy
    issue(8'd10, 8'd7, 8'd7, 1'b0, 16, 1'b1);
    repeat (5) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    bus.start = 1'b1;
    bus.h_in  = 8'd1;
    bus.x_in  = 8'd0;
    @(negedge clk);
    bus.start = 1'b0;

    // Back-to-back: start in the done cycle is accepted
    issue(8'd6, 8'd0, 8'd6, 1'b0, 11, 1'b1);
    k = 0;
    @(negedge clk);
    while (!bus.done && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("b2b_done_seen", int'(bus.done), 1);
    bus.start = 1'b1;
    bus.h_in  = 8'd25;
    bus.x_in  = 8'd24;
    @(posedge clk);
    #1;
    sb.push_back('{y: 8'd7, err: 1'b0, t0: cyc, lat: 11});
    bus.start = 1'b0;
    check("b2b_done_drop", int'(bus.done), 0);
    check("b2b_busy", int'(bus.busy), 1);

    // Drain
    k = 0;
    @(negedge clk);
    while ((bus.busy || sb.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
